predictor_update_scheduler: RTL and testbench
=============================================

# predictor_update_scheduler

Arbitrates the single-ported global (GP) and choice (CP) 4096-entry 2-bit counter tables of the tournament branch predictor between fetch-side lookups and execute-side resolution updates. Resolved branches are buffered in a small FIFO and drained into free table slots. The block enforces the Alpha 21264 training rules: GP is always trained, and CP is trained only on LP/GP disagreement. It also owns the non-speculative 12-bit path history register.

## Interface
Parameters:
- HIST, 12, path history / table index width
- DEPTH, 4, pending-update FIFO entries (power of two, ≥2)
- STARVE, 8, max consecutive lookup grants while updates are pending

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- LookupReq  in  1  fetch requests a table read this cycle
- LookupGnt  out  1  combinational; lookup granted this cycle
- ResolveValid  in  1  resolved branch presented
- ResolveReady  out  1  FIFO not full; registered count < DEPTH
- ResolveIdx  in  HIST  history value used at this branch's lookup
- BranchTaken  in  1  actual outcome
- LPresult  in  1  local predictor's prediction
- GPresult  in  1  global predictor's prediction
- PHresult  out  HIST  current path history; index for lookups
- TableIdx  out  HIST  registered table index
- TableRd  out  1  registered; lookup read command
- GWrite  out  1  registered; GP counter update
- GTaken  out  1  registered; GP train direction (1 = increment)
- CWrite  out  1  registered; CP counter update
- CTowardGlobal  out  1  registered; CP train direction (1 = toward global)
- Pending  out  clog2(DEPTH)+1  registered FIFO occupancy

## Operation
- FIFO enqueue on ResolveValid && ResolveReady. Entry = {ResolveIdx, BranchTaken, LPresult, GPresult}.
- On enqueue, PHresult <= {PHresult[HIST-2:0], BranchTaken}.
- No bypass: an entry enqueued in cycle N is dequeued no earlier than N+1.
- Per-cycle arbitration on registered count C and starve counter S:
  - C==0: grant lookup iff LookupReq.
  - C>0: issue update if !LookupReq, or C==DEPTH, or S==STARVE; otherwise grant lookup.
- S counts consecutive cycles with C>0 and a lookup granted. S clears on any update issue or when C==0, and saturates at STARVE.
- Command FSM (state = registered command): IDLE, LOOK, UPD. Next state is LOOK on a lookup grant, UPD on an update issue, IDLE otherwise. Any state may move to any state each cycle.
- LOOK: TableRd=1, TableIdx=PHresult sampled at grant.
- UPD (FIFO head popped at issue):
  - TableIdx=head.idx, GWrite=1, GTaken=head.taken.
  - CWrite=(head.LP != head.GP), CTowardGlobal=(head.GP == head.taken).
- Simultaneous enqueue and dequeue: C unchanged. Enqueue is blocked when C==DEPTH because ResolveReady=0.
- Pointers wrap modulo DEPTH.

## Timing
- Arbitration decision in cycle N. Table command outputs are valid in cycle N+1 for exactly one cycle.
- LookupGnt is combinational in cycle N. Fetch samples its table data two edges after the grant (table read latency owned by the table).
- ResolveReady and Pending reflect state after the previous edge.
- Worst-case update latency with LookupReq held high: STARVE+1 cycles from reaching the FIFO head.
- Reset (asynchronous, active-low, any time, including mid-drain):
  - FIFO flushed, C=0, S=0, PHresult=0, state IDLE.
  - All outputs 0 except ResolveReady=1.
  - Lost pending updates are acceptable.
- Outputs that are not asserted in the current state are driven 0, including TableIdx in IDLE.

## Test plan
- Reset: hold reset low 4 cycles -> all outputs 0, ResolveReady=1. Release with LookupReq=1 -> LookupGnt=1; next cycle TableRd=1, TableIdx=0.
- Idle drain: LookupReq=0, one resolve {idx=0x000, taken=1, LP=1, GP=1} -> Pending=1. Next cycle update issued. Following cycle: GWrite=1, GTaken=1, CWrite=0, TableIdx=0x000. PHresult=0x001.
- Choice training: resolve {idx=0x00F, taken=1, LP=0, GP=1} -> CWrite=1, CTowardGlobal=1. Resolve {idx=0x00F, taken=0, LP=0, GP=1} -> CWrite=1, CTowardGlobal=0, GTaken=0.
- Full FIFO: LookupReq=1, 4 back-to-back resolves -> ResolveReady=0 when Pending=4. The next cycle is an update (LookupGnt=0), after which ResolveReady=1.
- Starvation: LookupReq=1 continuously, 1 entry pending -> exactly 8 lookup grants, then 1 update, then lookups resume with S=0.
- Reset mid-drain: 3 entries pending, assert reset between edges -> outputs and Pending drop to 0 immediately. No GWrite after release.

Source files
------------

// File: rtl/predictor_update_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : predictor_update_scheduler_if                                   |
// | Purpose  : Bundles the lookup, resolve and table-command signals of the    |
// |            tournament-predictor update scheduler.                          |
// |   master : fetch/execute side (drives requests and resolved branches)      |
// |   slave  : scheduler side (grants, path history, table commands)           |
// | Signals  : LookupReq/LookupGnt      - fetch table-read arbitration          |
// |            ResolveValid/ResolveReady/ResolveIdx/BranchTaken/LPresult/      |
// |            GPresult                 - resolved-branch handshake            |
// |            PHresult                 - non-speculative path history         |
// |            TableIdx/TableRd/GWrite/GTaken/CWrite/CTowardGlobal            |
// |                                     - registered table command             |
// |            Pending                  - FIFO occupancy                       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface predictor_update_scheduler_if #(
   parameter int HIST  = 12,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            LookupReq;
   logic            LookupGnt;
   logic            ResolveValid;
   logic            ResolveReady;
   logic [HIST-1:0] ResolveIdx;
   logic            BranchTaken;
   logic            LPresult;
   logic            GPresult;
   logic [HIST-1:0] PHresult;
   logic [HIST-1:0] TableIdx;
   logic            TableRd;
   logic            GWrite;
   logic            GTaken;
   logic            CWrite;
   logic            CTowardGlobal;
   logic [CW-1:0]   Pending;

   modport master (
      output LookupReq, ResolveValid, ResolveIdx, BranchTaken, LPresult, GPresult,
      input  LookupGnt, ResolveReady, PHresult, TableIdx, TableRd, GWrite, GTaken,
             CWrite, CTowardGlobal, Pending
   );

   modport slave (
      input  LookupReq, ResolveValid, ResolveIdx, BranchTaken, LPresult, GPresult,
      output LookupGnt, ResolveReady, PHresult, TableIdx, TableRd, GWrite, GTaken,
             CWrite, CTowardGlobal, Pending
   );
endinterface
`default_nettype wire

// File: rtl/predictor_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : predictor_update_scheduler                                      |
// | Purpose  : Shares the single-ported global (GP) and choice (CP) counter    |
// |            tables between fetch lookups and resolved-branch training.      |
// |            Resolved branches queue in a small FIFO and drain into cycles   |
// |            fetch does not use; a starve counter bounds update latency.     |
// |            GP is always trained, CP only when LP and GP disagreed.         |
// |            Also owns the non-speculative path history register.            |
// | Ports    : clock - rising-edge clock                                       |
// |            reset - asynchronous active-low reset                           |
// |            bus   - predictor_update_scheduler_if.slave (all other I/O)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module predictor_update_scheduler #(
   parameter int HIST   = 12,
   parameter int DEPTH  = 4,
   parameter int STARVE = 8
) (
   input  logic                               clock,
   input  logic                               reset,
   predictor_update_scheduler_if.slave        bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE + 1);

   localparam logic [CW-1:0] c_full   = CW'(DEPTH);
   localparam logic [SW-1:0] c_starve = SW'(STARVE);

   // Command FSM: the state is the table command currently on the outputs.
   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_look = 2'd1;
   localparam logic [1:0] c_st_upd  = 2'd2;

   // Pending-update FIFO storage
   logic [HIST-1:0]  r_idx_mem [DEPTH];
   logic [DEPTH-1:0] r_tk_mem;
   logic [DEPTH-1:0] r_lp_mem;
   logic [DEPTH-1:0] r_gp_mem;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic [SW-1:0]    r_starve;
   logic [HIST-1:0]  r_ph;

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic [HIST-1:0]  r_cmd_idx;
   logic             r_cmd_tk;
   logic             r_cmd_cw;
   logic             r_cmd_ctg;

   logic             w_busy;
   logic             w_full;
   logic             w_ready;
   logic             w_upd;
   logic             w_look;
   logic             w_enq;
   logic [HIST-1:0]  w_head_idx;
   logic             w_head_tk;
   logic             w_head_lp;
   logic             w_head_gp;

   // ---------------------------------------------------------------- arbitration
   // Decisions use only the registered count, so an entry written this cycle
   // cannot be popped before the next one.
   assign w_busy  = (r_count != '0);
   assign w_full  = (r_count == c_full);
   assign w_ready = (r_count < c_full);
   assign w_upd   = w_busy & (~bus.LookupReq | w_full | (r_starve == c_starve));
   assign w_look  = bus.LookupReq & ~w_upd;
   assign w_enq   = bus.ResolveValid & w_ready;

   assign w_head_idx = r_idx_mem[r_rd_ptr];
   assign w_head_tk  = r_tk_mem[r_rd_ptr];
   assign w_head_lp  = r_lp_mem[r_rd_ptr];
   assign w_head_gp  = r_gp_mem[r_rd_ptr];

   // The grant is combinational; masking it with reset keeps every output
   // except ResolveReady at 0 while reset is held.
   assign bus.LookupGnt    = w_look & reset;
   assign bus.ResolveReady = w_ready;
   assign bus.Pending      = r_count;
   assign bus.PHresult     = r_ph;

   // ---------------------------------------------------------------- FIFO data
   // Contents need no reset: occupancy alone decides what is valid.
   always_ff @(posedge clock) begin
      if (w_enq) begin
         r_idx_mem[r_wr_ptr] <= bus.ResolveIdx;
         r_tk_mem[r_wr_ptr]  <= bus.BranchTaken;
         r_lp_mem[r_wr_ptr]  <= bus.LPresult;
         r_gp_mem[r_wr_ptr]  <= bus.GPresult;
      end
   end

   // ------------------------------------------- FIFO control, history, starve
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_starve <= '0;
         r_ph     <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
            r_ph     <= {r_ph[HIST-2:0], bus.BranchTaken};
         end
         if (w_upd) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_enq, w_upd})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         // Counts lookups granted over a waiting update; saturates so the
         // forced update is held until it actually issues.
         if (!w_busy || w_upd) begin
            r_starve <= '0;
         end else if (w_look && (r_starve != c_starve)) begin
            r_starve <= r_starve + SW'(1);
         end
      end
   end

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Command payload captured alongside the state transition.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cmd_idx <= '0;
         r_cmd_tk  <= 1'b0;
         r_cmd_cw  <= 1'b0;
         r_cmd_ctg <= 1'b0;
      end else begin
         r_cmd_idx <= '0;
         r_cmd_tk  <= 1'b0;
         r_cmd_cw  <= 1'b0;
         r_cmd_ctg <= 1'b0;
         if (w_look) begin
            r_cmd_idx <= r_ph;
         end else if (w_upd) begin
            r_cmd_idx <= w_head_idx;
            r_cmd_tk  <= w_head_tk;
            r_cmd_cw  <= w_head_lp ^ w_head_gp;
            r_cmd_ctg <= ~(w_head_gp ^ w_head_tk);
         end
      end
   end

   // ----------------------------------------------------------- FSM next state
   always_comb begin
      w_next_state = c_st_idle;
      if (w_look) begin
         w_next_state = c_st_look;
      end else if (w_upd) begin
         w_next_state = c_st_upd;
      end
   end

   // -------------------------------------------------------------- FSM outputs
   always_comb begin
      bus.TableIdx      = '0;
      bus.TableRd       = 1'b0;
      bus.GWrite        = 1'b0;
      bus.GTaken        = 1'b0;
      bus.CWrite        = 1'b0;
      bus.CTowardGlobal = 1'b0;
      case (r_state)
         c_st_look: begin
            bus.TableIdx = r_cmd_idx;
            bus.TableRd  = 1'b1;
         end
         c_st_upd: begin
            bus.TableIdx      = r_cmd_idx;
            bus.GWrite        = 1'b1;
            bus.GTaken        = r_cmd_tk;
            bus.CWrite        = r_cmd_cw;
            bus.CTowardGlobal = r_cmd_ctg;
         end
         default: begin
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_predictor_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_predictor_update_scheduler                                   |
// | Purpose  : Self-checking bench for predictor_update_scheduler. A reference |
// |            model tracks occupancy, starve count and path history; resolved |
// |            branches go into a scoreboard queue and are popped when the     |
// |            model issues an update, then compared with the DUT command one  |
// |            cycle later. Scenario tasks add directed checks.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_predictor_update_scheduler;
   localparam int HIST   = 12;
   localparam int DEPTH  = 4;
   localparam int STARVE = 8;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   predictor_update_scheduler_if #(.HIST(HIST), .DEPTH(DEPTH)) bus ();

   predictor_update_scheduler #(.HIST(HIST), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [HIST-1:0] idx;
      logic            tk;
      logic            lp;
      logic            gp;
   } res_t;

   res_t            sb_q[$];
   int              m_count;
   int              m_starve;
   logic [HIST-1:0] m_ph;
   logic [HIST+4:0] exp_cmd;   // {rd, gw, gt, cw, ctg, idx}
   logic [HIST+4:0] m_act;
   logic            m_upd, m_look, m_enq;
   res_t            m_head, m_new;

   // ---------------------------------------------------------- model/monitor
   // Inputs change only just after a rising edge, so the falling edge sees
   // the values the DUT decides on at the next rising edge.
   always @(negedge clock) begin
      if (!reset) begin
         sb_q.delete();
         m_count  = 0;
         m_starve = 0;
         m_ph     = '0;
         exp_cmd  = '0;
      end else begin
         m_upd  = (m_count > 0) && (!bus.LookupReq || m_count == DEPTH || m_starve == STARVE);
         m_look = bus.LookupReq && !m_upd;
         m_enq  = bus.ResolveValid && (m_count < DEPTH);

         checks++;
         if (bus.LookupGnt !== m_look) begin
            errors++;
            $display("FAIL mon_grant t=%0t got=%b exp=%b", $time, bus.LookupGnt, m_look);
         end
         checks++;
         if (bus.ResolveReady !== (m_count < DEPTH)) begin
            errors++;
            $display("FAIL mon_ready t=%0t got=%b exp=%b", $time, bus.ResolveReady, (m_count < DEPTH));
         end
         checks++;
         if (bus.Pending !== CW'(m_count)) begin
            errors++;
            $display("FAIL mon_pending t=%0t got=%0d exp=%0d", $time, bus.Pending, m_count);
         end
         checks++;
         if (bus.PHresult !== m_ph) begin
            errors++;
            $display("FAIL mon_phist t=%0t got=%h exp=%h", $time, bus.PHresult, m_ph);
         end
         m_act = {bus.TableRd, bus.GWrite, bus.GTaken, bus.CWrite, bus.CTowardGlobal, bus.TableIdx};
         checks++;
         if (m_act !== exp_cmd) begin
            errors++;
            $display("FAIL mon_cmd t=%0t got={rd,gw,gt,cw,ctg,idx}=%h exp=%h", $time, m_act, exp_cmd);
         end

         if (m_look) begin
            exp_cmd = {1'b1, 4'b0000, m_ph};
         end else if (m_upd) begin
            m_head  = sb_q.pop_front();
            exp_cmd = {1'b0, 1'b1, m_head.tk, (m_head.lp != m_head.gp), (m_head.gp == m_head.tk), m_head.idx};
         end else begin
            exp_cmd = '0;
         end

         if (m_enq) begin
            m_new.idx = bus.ResolveIdx;
            m_new.tk  = bus.BranchTaken;
            m_new.lp  = bus.LPresult;
            m_new.gp  = bus.GPresult;
            sb_q.push_back(m_new);
            m_ph = {m_ph[HIST-2:0], bus.BranchTaken};
         end

         if (m_count == 0 || m_upd) m_starve = 0;
         else if (m_look && m_starve < STARVE) m_starve++;
         m_count = m_count + (m_enq ? 1 : 0) - (m_upd ? 1 : 0);
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_resolve(input logic [HIST-1:0] idx, input logic tk,
                                input logic lp, input logic gp);
      bus.ResolveValid = 1'b1;
      bus.ResolveIdx   = idx;
      bus.BranchTaken  = tk;
      bus.LPresult     = lp;
      bus.GPresult     = gp;
   endtask

   task automatic drain();
      bus.LookupReq    = 1'b0;
      bus.ResolveValid = 1'b0;
      for (int i = 0; i < 20 && bus.Pending != 0; i++) cyc();
      checks++;
      if (bus.Pending !== '0) begin
         errors++;
         $display("FAIL drain_timeout got=%0d exp=0", bus.Pending);
      end
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.LookupReq    = 1'b0;
      bus.ResolveValid = 1'b0;
      repeat (4) cyc();
      #1;
      checks++;
      if ({bus.LookupGnt, bus.TableRd, bus.TableIdx, bus.GWrite, bus.GTaken, bus.CWrite,
           bus.CTowardGlobal, bus.Pending, bus.PHresult} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got gnt=%b rd=%b idx=%h gw=%b gt=%b cw=%b ctg=%b pend=%0d ph=%h exp=all0",
                  bus.LookupGnt, bus.TableRd, bus.TableIdx, bus.GWrite, bus.GTaken, bus.CWrite,
                  bus.CTowardGlobal, bus.Pending, bus.PHresult);
      end
      checks++;
      if (bus.ResolveReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=1", bus.ResolveReady);
      end
      cyc();
      reset = 1'b1;
      bus.LookupReq = 1'b1;
      #1;
      checks++;
      if (bus.LookupGnt !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_grant got=%b exp=1", bus.LookupGnt);
      end
      cyc();
      bus.LookupReq = 1'b0;
      #1;
      checks++;
      if ({bus.TableRd, bus.TableIdx} !== {1'b1, 12'h000}) begin
         errors++;
         $display("FAIL reset_first_read got rd=%b idx=%h exp rd=1 idx=000", bus.TableRd, bus.TableIdx);
      end
      cyc();
   endtask

   task automatic test_idle_drain();
      bus.LookupReq = 1'b0;
      drive_resolve(12'h000, 1'b1, 1'b1, 1'b1);
      cyc();
      bus.ResolveValid = 1'b0;
      #1;
      checks++;
      if ({bus.Pending, bus.PHresult} !== {CW'(1), 12'h001}) begin
         errors++;
         $display("FAIL idle_enqueue got pend=%0d ph=%h exp pend=1 ph=001", bus.Pending, bus.PHresult);
      end
      cyc();
      #1;
      checks++;
      if ({bus.GWrite, bus.GTaken, bus.CWrite, bus.TableIdx} !== {3'b110, 12'h000}) begin
         errors++;
         $display("FAIL idle_update got gw=%b gt=%b cw=%b idx=%h exp gw=1 gt=1 cw=0 idx=000",
                  bus.GWrite, bus.GTaken, bus.CWrite, bus.TableIdx);
      end
      drain();
   endtask

   task automatic test_choice();
      // {idx, taken, LP, GP} -> expected {CWrite, CTowardGlobal, GTaken}
      logic [HIST+2:0] vec [3];
      logic [2:0]      exp [3];
      vec[0] = {12'h00F, 3'b101}; exp[0] = 3'b111;
      vec[1] = {12'h00F, 3'b001}; exp[1] = 3'b100;
      vec[2] = {12'h0A5, 3'b010}; exp[2] = 3'b110;
      for (int i = 0; i < 3; i++) begin
         drive_resolve(vec[i][HIST+2:3], vec[i][2], vec[i][1], vec[i][0]);
         cyc();
         bus.ResolveValid = 1'b0;
         cyc();
         #1;
         checks++;
         if ({bus.GWrite, bus.CWrite, bus.CTowardGlobal, bus.GTaken, bus.TableIdx} !==
             {1'b1, exp[i], vec[i][HIST+2:3]}) begin
            errors++;
            $display("FAIL choice_%0d got gw=%b cw=%b ctg=%b gt=%b idx=%h exp gw=1 cw/ctg/gt=%b idx=%h",
                     i, bus.GWrite, bus.CWrite, bus.CTowardGlobal, bus.GTaken, bus.TableIdx,
                     exp[i], vec[i][HIST+2:3]);
         end
      end
      drain();
   endtask

   task automatic test_full();
      bus.LookupReq = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_resolve(HIST'(12'h111 * (i + 1)), i[0], i[1], ~i[0]);
         #1;
         checks++;
         if (bus.LookupGnt !== 1'b1) begin
            errors++;
            $display("FAIL full_fill_grant_%0d got=%b exp=1", i, bus.LookupGnt);
         end
         cyc();
      end
      // A fifth resolve is offered while full and must be refused.
      drive_resolve(12'hBAD, 1'b1, 1'b0, 1'b1);
      #1;
      checks++;
      if ({bus.Pending, bus.ResolveReady, bus.LookupGnt} !== {CW'(4), 2'b00}) begin
         errors++;
         $display("FAIL full_stall got pend=%0d ready=%b gnt=%b exp pend=4 ready=0 gnt=0",
                  bus.Pending, bus.ResolveReady, bus.LookupGnt);
      end
      cyc();
      bus.ResolveValid = 1'b0;
      #1;
      checks++;
      if ({bus.Pending, bus.ResolveReady, bus.GWrite} !== {CW'(3), 2'b11}) begin
         errors++;
         $display("FAIL full_after got pend=%0d ready=%b gw=%b exp pend=3 ready=1 gw=1",
                  bus.Pending, bus.ResolveReady, bus.GWrite);
      end
      drain();
   endtask

   task automatic test_starve();
      int grants;
      for (int rep = 0; rep < 2; rep++) begin
         bus.LookupReq = 1'b1;
         drive_resolve(HIST'(12'h123 + rep), rep[0], 1'b1, 1'b0);
         cyc();
         bus.ResolveValid = 1'b0;
         grants = 0;
         for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.LookupGnt !== 1'b1) break;
            grants++;
            cyc();
         end
         checks++;
         if (grants != STARVE) begin
            errors++;
            $display("FAIL starve_grants_%0d got=%0d exp=%0d", rep, grants, STARVE);
         end
         cyc();
         #1;
         checks++;
         if ({bus.GWrite, bus.LookupGnt} !== 2'b11) begin
            errors++;
            $display("FAIL starve_resume_%0d got gw=%b gnt=%b exp gw=1 gnt=1", rep, bus.GWrite, bus.LookupGnt);
         end
         cyc();
      end
      drain();
   endtask

   task automatic test_reset_mid_drain();
      bus.LookupReq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_resolve(HIST'(12'h700 + i), 1'b1, 1'b0, 1'b1);
         cyc();
      end
      bus.ResolveValid = 1'b0;
      checks++;
      if (bus.Pending !== CW'(3)) begin
         errors++;
         $display("FAIL middrain_setup got pend=%0d exp=3", bus.Pending);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({bus.Pending, bus.ResolveReady, bus.LookupGnt, bus.TableRd, bus.GWrite, bus.TableIdx, bus.PHresult}
          !== {CW'(0), 4'b1000, 12'h000, 12'h000}) begin
         errors++;
         $display("FAIL middrain_reset got pend=%0d ready=%b gnt=%b rd=%b gw=%b idx=%h ph=%h exp pend=0 ready=1 rest=0",
                  bus.Pending, bus.ResolveReady, bus.LookupGnt, bus.TableRd, bus.GWrite, bus.TableIdx, bus.PHresult);
      end
      cyc();
      cyc();
      reset = 1'b1;
      bus.LookupReq = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if ({bus.GWrite, bus.Pending} !== {1'b0, CW'(0)}) begin
            errors++;
            $display("FAIL middrain_after_%0d got gw=%b pend=%0d exp gw=0 pend=0", i, bus.GWrite, bus.Pending);
         end
         cyc();
      end
   endtask

   initial begin
      bus.LookupReq    = 1'b0;
      bus.ResolveValid = 1'b0;
      bus.ResolveIdx   = '0;
      bus.BranchTaken  = 1'b0;
      bus.LPresult     = 1'b0;
      bus.GPresult     = 1'b0;
      test_reset();
      test_idle_drain();
      test_choice();
      test_full();
      test_starve();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "bench time limit");
   end

endmodule
`default_nettype wire
